// File: rtl/axi_pkg.sv
// Shared AXI read-arbiter constants, FSM state and requester-select types.
package axi_pkg;

    localparam logic [2:0] AXSIZE_1B = 3'b000;
    localparam logic [2:0] AXSIZE_2B = 3'b001;
    localparam logic [2:0] AXSIZE_4B = 3'b010;
    localparam logic [2:0] AXSIZE_8B = 3'b011;

    localparam logic [1:0] AXBURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] AXPROT_INSTR = 3'b100;
    localparam logic [2:0] AXPROT_DATA  = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } arb_state_e;

    typedef enum logic {
        SEL_IFU,
        SEL_LSU
    } req_sel_e;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Requester and AXI read-channel bundle for the IFU/LSU read arbiter.
interface axi_rd_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) ();

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_resp_data;
    logic              ifu_resp_err;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic [2:0]        lsu_req_size;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_resp_data;
    logic              lsu_resp_err;

    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;

    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    logic              rid_err;

    modport master (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready,
        output ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        input  lsu_req_valid, lsu_req_addr, lsu_req_size,
        output lsu_req_ready,
        output lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        output ARID, ARADDR, ARLEN, ARSIZE,
        output ARBURST, ARPROT, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output rid_err
    );

    modport slave (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready,
        input  ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        output lsu_req_valid, lsu_req_addr, lsu_req_size,
        input  lsu_req_ready,
        input  lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        input  ARID, ARADDR, ARLEN, ARSIZE,
        input  ARBURST, ARPROT, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  rid_err
    );

endinterface

// File: rtl/axi_arb_grant.sv
// Requester grant policy: fixed LSU priority, or round-robin on ties
// when AXI_ARB_RR_EN is defined.
module axi_arb_grant
    import axi_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     ifu_valid,
    input  logic     lsu_valid,
    input  logic     upd,
    output logic     gnt,
    output req_sel_e sel
);

    assign gnt = ifu_valid | lsu_valid;

`ifdef AXI_ARB_RR_EN
    req_sel_e last_grant;

    // Reset to IFU so the first tie goes to the LSU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= SEL_IFU;
        end else if (upd) begin
            last_grant <= sel;
        end
    end

    always_comb begin
        sel = SEL_IFU;
        if (ifu_valid && lsu_valid) begin
            sel = (last_grant == SEL_IFU) ? SEL_LSU : SEL_IFU;
        end else if (lsu_valid) begin
            sel = SEL_LSU;
        end
    end
`else
    logic unused;
    assign unused = clk ^ rst ^ upd;
    assign sel    = lsu_valid ? SEL_LSU : SEL_IFU;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Single-outstanding, single-beat AXI4 read port shared by IFU and LSU.
// Optional round-robin tie-break via AXI_ARB_RR_EN.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned IFU_ID   = 0,
    parameter int unsigned LSU_ID   = 1,
    parameter logic [2:0]  IFU_SIZE = AXSIZE_4B
) (
    input logic              clk,
    input logic              rst,
    axi_rd_arbiter_if.master bus
);

    arb_state_e        state;
    req_sel_e          sel;
    req_sel_e          cur;
    logic              gnt;
    logic              take;

    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [2:0]        ar_size;
    logic [2:0]        ar_prot;
    logic              ar_valid;
    logic              r_ready;
    logic              rid_err_q;

    logic              ifu_rv;
    logic              ifu_err;
    logic [DATA_W-1:0] ifu_data;
    logic              lsu_rv;
    logic              lsu_err;
    logic [DATA_W-1:0] lsu_data;

    logic              unused_rlast;
    assign unused_rlast = bus.RLAST;

    axi_arb_grant u_grant (
        .clk       (clk),
        .rst       (rst),
        .ifu_valid (bus.ifu_req_valid),
        .lsu_valid (bus.lsu_req_valid),
        .upd       (take),
        .gnt       (gnt),
        .sel       (sel)
    );

    assign take = !rst && (state == S_IDLE) && gnt;

    assign bus.ifu_req_ready = take && (sel == SEL_IFU);
    assign bus.lsu_req_ready = take && (sel == SEL_LSU);

    assign bus.ARID    = ar_id;
    assign bus.ARADDR  = ar_addr;
    assign bus.ARLEN   = 8'd0;
    assign bus.ARSIZE  = ar_size;
    assign bus.ARBURST = AXBURST_INCR;
    assign bus.ARPROT  = ar_prot;
    assign bus.ARVALID = ar_valid;
    assign bus.RREADY  = r_ready;
    assign bus.rid_err = rid_err_q;

    assign bus.ifu_resp_valid = ifu_rv;
    assign bus.ifu_resp_data  = ifu_data;
    assign bus.ifu_resp_err   = ifu_err;
    assign bus.lsu_resp_valid = lsu_rv;
    assign bus.lsu_resp_data  = lsu_data;
    assign bus.lsu_resp_err   = lsu_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cur       <= SEL_IFU;
            ar_id     <= '0;
            ar_addr   <= '0;
            ar_size   <= '0;
            ar_prot   <= '0;
            ar_valid  <= 1'b0;
            r_ready   <= 1'b0;
            rid_err_q <= 1'b0;
            ifu_rv    <= 1'b0;
            ifu_err   <= 1'b0;
            ifu_data  <= '0;
            lsu_rv    <= 1'b0;
            lsu_err   <= 1'b0;
            lsu_data  <= '0;
        end else begin
            ifu_rv <= 1'b0;
            lsu_rv <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (take) begin
                        state    <= S_ADDR;
                        ar_valid <= 1'b1;
                        cur      <= sel;
                        if (sel == SEL_LSU) begin
                            ar_id   <= ID_W'(LSU_ID);
                            ar_addr <= bus.lsu_req_addr;
                            ar_size <= bus.lsu_req_size;
                            ar_prot <= AXPROT_DATA;
                        end else begin
                            ar_id   <= ID_W'(IFU_ID);
                            ar_addr <= bus.ifu_req_addr;
                            ar_size <= IFU_SIZE;
                            ar_prot <= AXPROT_INSTR;
                        end
                    end
                end
                S_ADDR: begin
                    if (bus.ARREADY) begin
                        state    <= S_DATA;
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                    end
                end
                S_DATA: begin
                    // Beats with a foreign ID are drained and flagged.
                    if (bus.RVALID) begin
                        if (bus.RID == ar_id) begin
                            state   <= S_IDLE;
                            r_ready <= 1'b0;
                            if (cur == SEL_LSU) begin
                                lsu_rv   <= 1'b1;
                                lsu_data <= bus.RDATA;
                                lsu_err  <= bus.RRESP != RESP_OKAY;
                            end else begin
                                ifu_rv   <= 1'b1;
                                ifu_data <= bus.RDATA;
                                ifu_err  <= bus.RRESP != RESP_OKAY;
                            end
                        end else begin
                            rid_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter against a transaction-level model.
module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    axi_rd_arbiter_if bus ();

    axi_rd_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          lsu;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [3:0]  id;
        logic [2:0]  prot;
    } txn_t;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
    } beat_t;

    int n_chk  = 0;
    int n_fail = 0;

    int p_ifu, p_lsu, p_arready, p_rvalid, p_stray, p_err;
    bit          force_data;
    logic [63:0] forced;

    bit          ifu_pend, lsu_pend;
    logic [63:0] ifu_addr, lsu_addr;
    logic [2:0]  lsu_size;

    // 0: idle, 1: address phase, 2: waiting for the beat
    int          phase;
    txn_t        cur;
    bit          pulse_due, pulse_lsu, pulse_err;
    logic [63:0] pulse_data;
    bit          exp_rid_err;
`ifdef AXI_ARB_RR_EN
    bit          last_lsu;
`endif

    beat_t       beats[$];
    bit          r_show;
    beat_t       shown;

    int cyc, grant_cyc, pulse_cyc;
    int pulses_seen, pulses_exp;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic model_reset();
        phase       = 0;
        pulse_due   = 0;
        exp_rid_err = 0;
`ifdef AXI_ARB_RR_EN
        last_lsu    = 0;
`endif
        beats.delete();
        r_show      = 0;
        ifu_pend    = 0;
        lsu_pend    = 0;
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_addr  = '0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_addr  = '0;
        bus.lsu_req_size  = '0;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        bus.RID     = '0;
        bus.RDATA   = '0;
        bus.RRESP   = '0;
        bus.RLAST   = 1'b0;
    endtask

    task automatic cycle();
        bit    g_ifu, g_lsu;
        beat_t b;
        @(negedge clk);
        cyc++;
        if (!ifu_pend && $urandom_range(99) < p_ifu) begin
            ifu_pend = 1;
            ifu_addr = {$urandom, $urandom};
        end
        if (!lsu_pend && $urandom_range(99) < p_lsu) begin
            lsu_pend = 1;
            lsu_addr = {$urandom, $urandom};
            lsu_size = 3'($urandom_range(3));
        end
        bus.ifu_req_valid = ifu_pend;
        bus.ifu_req_addr  = ifu_addr;
        bus.lsu_req_valid = lsu_pend;
        bus.lsu_req_addr  = lsu_addr;
        bus.lsu_req_size  = lsu_size;
        bus.ARREADY = ($urandom_range(99) < p_arready);
        if (!r_show && beats.size() > 0
            && $urandom_range(99) < p_rvalid) begin
            r_show = 1;
            shown  = beats[0];
        end
        bus.RVALID = r_show;
        bus.RID    = r_show ? shown.id : 4'($urandom);
        bus.RDATA  = r_show ? shown.data : {$urandom, $urandom};
        bus.RRESP  = r_show ? shown.resp : 2'($urandom);
        bus.RLAST  = 1'($urandom);
        #1;
        g_ifu = 0;
        g_lsu = 0;
        if (phase == 0) begin
            if (ifu_pend && lsu_pend) begin
`ifdef AXI_ARB_RR_EN
                g_lsu = !last_lsu;
`else
                g_lsu = 1;
`endif
                g_ifu = !g_lsu;
            end else begin
                g_ifu = ifu_pend;
                g_lsu = lsu_pend;
            end
        end
        chk("ifu_ready", bus.ifu_req_ready, g_ifu);
        chk("lsu_ready", bus.lsu_req_ready, g_lsu);
        chk("arvalid", bus.ARVALID, phase == 1);
        chk("rready", bus.RREADY, phase == 2);
        chk("ifu_rv", bus.ifu_resp_valid,
            pulse_due && !pulse_lsu);
        chk("lsu_rv", bus.lsu_resp_valid,
            pulse_due && pulse_lsu);
        chk("rid_err", bus.rid_err, exp_rid_err);
        if (pulse_due && pulse_lsu) begin
            chk("lsu_data", bus.lsu_resp_data, pulse_data);
            chk("lsu_err", bus.lsu_resp_err, pulse_err);
        end
        if (pulse_due && !pulse_lsu) begin
            chk("ifu_data", bus.ifu_resp_data, pulse_data);
            chk("ifu_err", bus.ifu_resp_err, pulse_err);
        end
        if (phase == 1) begin
            chk("arid", bus.ARID, cur.id);
            chk("araddr", bus.ARADDR, cur.addr);
            chk("arsize", bus.ARSIZE, cur.size);
            chk("arprot", bus.ARPROT, cur.prot);
            chk("arlen", bus.ARLEN, 0);
            chk("arburst", bus.ARBURST, 2'b01);
        end
        if (bus.ifu_resp_valid || bus.lsu_resp_valid)
            pulse_cyc = cyc;
        pulses_seen += int'(bus.ifu_resp_valid)
                     + int'(bus.lsu_resp_valid);

        pulse_due = 0;
        if (phase == 2 && r_show) begin
            b = beats.pop_front();
            r_show = 0;
            if (b.id == cur.id) begin
                pulse_due  = 1;
                pulse_lsu  = cur.lsu;
                pulse_data = b.data;
                pulse_err  = (b.resp != 2'b00);
                phase      = 0;
                pulses_exp++;
            end else begin
                exp_rid_err = 1;
            end
        end else if (phase == 1 && bus.ARREADY) begin
            phase = 2;
            if ($urandom_range(99) < p_stray)
                beats.push_back('{4'd3, {$urandom, $urandom}, 2'b00});
            b.id   = cur.id;
            b.data = force_data ? forced : {$urandom, $urandom};
            b.resp = ($urandom_range(99) < p_err)
                   ? 2'($urandom_range(3, 1)) : 2'b00;
            beats.push_back(b);
        end else if (g_ifu || g_lsu) begin
            cur.lsu  = g_lsu;
            cur.addr = g_lsu ? lsu_addr : ifu_addr;
            cur.size = g_lsu ? lsu_size : 3'b010;
            cur.id   = g_lsu ? 4'd1 : 4'd0;
            cur.prot = g_lsu ? 3'b000 : 3'b100;
            phase    = 1;
            grant_cyc = cyc;
`ifdef AXI_ARB_RR_EN
            last_lsu = g_lsu;
`endif
            if (g_lsu) lsu_pend = 0;
            else       ifu_pend = 0;
        end
    endtask

    task automatic drain();
        bit done;
        p_ifu = 0;
        p_lsu = 0;
        for (int i = 0; i < 300; i++) begin
            done = (phase == 0) && !pulse_due
                && !ifu_pend && !lsu_pend;
            if (done) break;
            cycle();
        end
        done = (phase == 0) && !pulse_due
            && !ifu_pend && !lsu_pend;
        chk("drain", done, 1);
    endtask

    initial begin
        p_ifu = 0; p_lsu = 0; p_arready = 100;
        p_rvalid = 100; p_stray = 0; p_err = 0;
        force_data = 0; forced = '0;
        ifu_addr = '0; lsu_addr = '0; lsu_size = '0;
        cyc = 0; grant_cyc = 0; pulse_cyc = 0;
        pulses_seen = 0; pulses_exp = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_arvalid", bus.ARVALID, 0);
        chk("rst_rready", bus.RREADY, 0);
        chk("rst_araddr", bus.ARADDR, 0);
        chk("rst_arid", bus.ARID, 0);
        chk("rst_rv", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
        chk("rst_rid_err", bus.rid_err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Lone fetch with known payload
        ifu_pend = 1;
        ifu_addr = 64'h8000_0000;
        force_data = 1;
        forced = 64'h1234_5678;
        drain();
        force_data = 0;
        chk("ifu_latency", pulse_cyc - grant_cyc, 3);

        // Simultaneous requests, then sustained ties
        ifu_pend = 1; ifu_addr = 64'h8000_0040;
        lsu_pend = 1; lsu_addr = 64'h9000_0008;
        lsu_size = 3'b011;
        drain();
        p_ifu = 100; p_lsu = 100;
        repeat (16) cycle();
        drain();

        // Address phase stalled
        p_arready = 0;
        lsu_pend = 1; lsu_addr = 64'hA000_0010;
        lsu_size = 3'b001;
        ifu_pend = 1; ifu_addr = 64'h8000_0100;
        repeat (7) cycle();
        p_arready = 100;
        drain();

        // Error response on a load
        p_err = 100;
        lsu_pend = 1; lsu_addr = 64'hB000_0000;
        drain();
        p_err = 0;

        // Stray RID ahead of the real beat
        p_stray = 100;
        ifu_pend = 1; ifu_addr = 64'h8000_0200;
        drain();
        p_stray = 0;

        // Random soak
        p_arready = 50; p_rvalid = 50;
        p_stray = 10; p_err = 20;
        for (int i = 0; i < 3000; i++) begin
            p_ifu = 30;
            p_lsu = 30;
            cycle();
        end
        drain();

        // Reset while waiting for the beat
        p_arready = 100; p_rvalid = 0; p_stray = 0;
        ifu_pend = 1; ifu_addr = 64'h8000_0300;
        for (int i = 0; i < 20 && phase != 2; i++) cycle();
        chk("reach_data", phase, 2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_arvalid", bus.ARVALID, 0);
        chk("arst_rready", bus.RREADY, 0);
        chk("arst_rv", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
        chk("arst_rid_err", bus.rid_err, 0);
        chk("arst_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        p_rvalid = 100;
        ifu_pend = 1; ifu_addr = 64'h8000_0400;
        drain();
        chk("pulse_count", pulses_seen, pulses_exp);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
